tape_recorder: RTL

- Records the Spectrum MIC/ear square wave into a CSW1 (RLE, v1.01) byte stream in the shared SDRAM tape buffer, so a saved tape can be downloaded later.
- It is the writer counterpart to the CSW player. It samples mic_in at SAMPLE_RATE, derived from the 3.5 MHz ce, and run-length encodes the time between level changes.
- It emits the 32-byte CSW1 header, then pulse bytes, over a req/ack write port.

---
 rtl/tape_recorder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tape_recorder.sv
// Records the MIC square wave into a CSW1 (RLE) byte stream over a req/ack write port.
// Optional TAPE_REC_FILTER_EN: a level change is accepted only after 3 consecutive matching samples.
module tape_recorder #(
    parameter int unsigned CLOCK       = 3500000,
    parameter int unsigned SAMPLE_RATE = 44100,
    parameter logic [24:0] MAX_SIZE    = 25'h1FFFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        mic_in,
    input  logic        rec,
    output logic        recording,
    output logic        full,
    output logic        overrun,
    output logic [24:0] size,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic [24:0] addr,
    output logic [7:0]  dout
);

    localparam int unsigned SIZE_W  = 25;
    localparam int unsigned CNT_W   = 32;
    localparam logic [32:0]  RATE_W  = 33'(SAMPLE_RATE);
    localparam logic [32:0]  CLOCK_W = 33'(CLOCK);
    localparam logic [175:0] MAGIC   = "Compressed Square Wave";

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_acc, w_acc_nx;
    logic [32:0]         w_acc_sum;
    logic                w_tick;
    logic                r_mic_s1, r_mic_s2, r_rec_q, r_pol, r_last;
    logic [CNT_W-1:0]    r_cnt, w_cnt_inc, r_pend;
    logic                r_pend_vld;
    logic [2:0]          r_bidx;
    logic [4:0]          r_hidx;
    logic                r_wr_req, r_full, r_overrun, r_recording;
    logic [SIZE_W-1:0]   r_addr, r_size;
    logic [7:0]          r_dout;
    logic                w_rec_rise, w_ack_ok, w_src_vld, w_full_hit, w_long, w_last_byte;
    logic [7:0]          w_src_byte, w_pulse_byte, w_hdr_byte;
    logic [255:0]        w_hdr;
    logic                w_differs, w_accept;
    logic [CNT_W-1:0]    w_pulse, w_cnt_restart;

    // Fractional sample-rate tick from the CLOCK-rate enable
    assign w_acc_sum = 33'(r_acc) + RATE_W;
    assign w_tick    = ce && (w_acc_sum >= CLOCK_W);
    assign w_acc_nx  = w_tick ? CNT_W'(w_acc_sum - CLOCK_W) : CNT_W'(w_acc_sum);

    assign w_rec_rise = rec && !r_rec_q;
    assign w_ack_ok   = r_wr_req && wr_ack;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_differs  = (r_mic_s2 != r_last);

`ifdef TAPE_REC_FILTER_EN
    logic [1:0]       r_flt;
    logic [CNT_W-1:0] r_flt_pulse;

    // Candidate change must persist for 3 ticks; pulse length is frozen at the first one
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_flt       <= '0;
            r_flt_pulse <= '0;
        end else if (r_state != S_RUN) begin
            r_flt <= '0;
        end else if (w_tick) begin
            if (!w_differs || r_flt == 2'd2) begin
                r_flt <= '0;
            end else begin
                if (r_flt == 2'd0) r_flt_pulse <= r_cnt;
                r_flt <= r_flt + 2'd1;
            end
        end
    end

    assign w_accept      = w_tick && w_differs && (r_flt == 2'd2);
    assign w_pulse       = r_flt_pulse;
    assign w_cnt_restart = CNT_W'(3);
`else
    assign w_accept      = w_tick && w_differs;
    assign w_pulse       = r_cnt;
    assign w_cnt_restart = CNT_W'(1);
`endif

    // Header image, byte 0 in the top bits
    assign w_hdr = {MAGIC, 8'h1A, 8'h01, 8'h01, RATE_W[7:0], RATE_W[15:8], 8'h01,
                    7'b0, r_pol, 24'h000000};
    assign w_hdr_byte = w_hdr[{~r_hidx, 3'b000} +: 8];

    assign w_long      = (r_pend[31:8] != '0);
    assign w_last_byte = !w_long || (r_bidx == 3'd4);

    always_comb begin
        w_pulse_byte = 8'h00;
        case (r_bidx)
            3'd0:    w_pulse_byte = w_long ? 8'h00 : r_pend[7:0];
            3'd1:    w_pulse_byte = r_pend[7:0];
            3'd2:    w_pulse_byte = r_pend[15:8];
            3'd3:    w_pulse_byte = r_pend[23:16];
            3'd4:    w_pulse_byte = r_pend[31:24];
            default: w_pulse_byte = 8'h00;
        endcase
    end

    assign w_src_vld  = (r_state == S_HDR) ||
                        (((r_state == S_RUN) || (r_state == S_FLUSH)) && r_pend_vld);
    assign w_src_byte = (r_state == S_HDR) ? w_hdr_byte : w_pulse_byte;
    assign w_full_hit = w_src_vld && !r_wr_req && (r_size == MAX_SIZE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_rec_rise) w_state_nx = S_HDR;
            S_HDR: begin
                if (w_full_hit)                          w_state_nx = S_DONE;
                else if (w_ack_ok && r_hidx == 5'd31)    w_state_nx = rec ? S_RUN : S_FLUSH;
            end
            S_RUN: begin
                if (w_full_hit) w_state_nx = S_DONE;
                else if (!rec)  w_state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (w_full_hit)                             w_state_nx = S_DONE;
                else if (!r_pend_vld && r_cnt == '0)        w_state_nx = S_DONE;
            end
            S_DONE:  if (!rec) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mic_s1 <= 1'b0;
            r_mic_s2 <= 1'b0;
            r_rec_q  <= 1'b0;
        end else begin
            if (ce) r_acc <= w_acc_nx;
            r_mic_s1 <= mic_in;
            r_mic_s2 <= r_mic_s1;
            r_rec_q  <= rec;
        end
    end

    // Write port, header/pulse sequencing and run-length counting
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pol       <= 1'b0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_bidx      <= '0;
            r_hidx      <= '0;
            r_wr_req    <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_size      <= '0;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
            r_recording <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_rec_rise) begin
                r_size     <= '0;
                r_full     <= 1'b0;
                r_overrun  <= 1'b0;
                r_pol      <= r_mic_s2;
                r_hidx     <= '0;
                r_pend_vld <= 1'b0;
                r_bidx     <= '0;
                r_cnt      <= '0;
            end

            if (w_ack_ok) begin
                r_wr_req <= 1'b0;
                r_size   <= r_size + SIZE_W'(1);
                if (r_state == S_HDR) begin
                    r_hidx <= r_hidx + 5'd1;
                end else if (w_last_byte) begin
                    r_pend_vld <= 1'b0;
                    r_bidx     <= '0;
                end else begin
                    r_bidx <= r_bidx + 3'd1;
                end
            end else if (w_src_vld && !r_wr_req) begin
                if (r_size == MAX_SIZE) begin
                    r_full <= 1'b1;
                end else begin
                    r_wr_req <= 1'b1;
                    r_addr   <= r_size;
                    r_dout   <= w_src_byte;
                end
            end

            if (r_state == S_HDR && w_ack_ok && r_hidx == 5'd31) begin
                r_cnt  <= '0;
                r_last <= r_pol;
            end

            // A zero-length first pulse (change on the very first tick) is not emitted
            if (r_state == S_RUN && w_tick) begin
                if (w_accept && !r_pend_vld) begin
                    if (w_pulse != '0) begin
                        r_pend     <= w_pulse;
                        r_pend_vld <= 1'b1;
                        r_bidx     <= '0;
                    end
                    r_last <= r_mic_s2;
                    r_cnt  <= w_cnt_restart;
                end else begin
                    if (w_accept) r_overrun <= 1'b1;
                    r_cnt <= w_cnt_inc;
                end
            end

            if (r_state == S_FLUSH && !r_pend_vld && r_cnt != '0) begin
                r_pend     <= r_cnt;
                r_pend_vld <= 1'b1;
                r_bidx     <= '0;
                r_cnt      <= '0;
            end

            r_recording <= (w_state_nx == S_HDR) || (w_state_nx == S_RUN) ||
                           (w_state_nx == S_FLUSH);
        end
    end

    assign recording = r_recording;
    assign full      = r_full;
    assign overrun   = r_overrun;
    assign size      = r_size;
    assign wr_req    = r_wr_req;
    assign addr      = r_addr;
    assign dout      = r_dout;

endmodule
